// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-side encodings for MAIN_MEMORY, both caches and the arbiter.
// Request codes, status codes and the arbiter state enum.
package mem_defs;

  localparam logic [1:0] VIS_IDLE  = 2'b00;
  localparam logic [1:0] VIS_READ  = 2'b01;
  localparam logic [1:0] VIS_WRITE = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;
  localparam logic [1:0] ST_ERROR = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D
  } arb_state_e;

  function automatic logic vis_active(
    input logic [1:0] s
  );
    return (s == VIS_READ) || (s == VIS_WRITE);
  endfunction

  function automatic logic st_final(
    input logic [1:0] s
  );
    return (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising I-cache and D-cache requests onto the
// single memory port, with a watchdog that aborts hung accesses.
module mem_port_arbiter
  import mem_defs::*;
#(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int TIMEOUT          = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                i_vis_signal,
  input  logic [ADDR_WIDTH-1:0]     i_vis_addr,
  output logic [1:0]                i_status,
  output logic [LEN-1:0]            i_data,
  input  logic [1:0]                d_vis_signal,
  input  logic [ADDR_WIDTH-1:0]     d_vis_addr,
  input  logic [LEN-1:0]            d_written_data,
  input  logic [2:0]                d_data_type,
  input  logic [ENTRY_INDEX_SIZE:0] d_length,
  output logic [1:0]                d_status,
  output logic [LEN-1:0]            d_data,
  output logic [1:0]                mem_vis_signal,
  output logic [ADDR_WIDTH-1:0]     mem_vis_addr,
  output logic [LEN-1:0]            mem_written_data,
  output logic [2:0]                mem_data_type,
  output logic [ENTRY_INDEX_SIZE:0] mem_length,
  input  logic [1:0]                mem_status,
  input  logic [LEN-1:0]            mem_data
);

  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  arb_state_e                state_q;
  logic                      last_d_q;
  logic [WD_W-1:0]           wd_q;
  logic [1:0]                i_status_q;
  logic [1:0]                d_status_q;
  logic [LEN-1:0]            i_data_q;
  logic [LEN-1:0]            d_data_q;
  logic [1:0]                mem_sig_q;
  logic [ADDR_WIDTH-1:0]     mem_addr_q;
  logic [LEN-1:0]            mem_wdata_q;
  logic [2:0]                mem_type_q;
  logic [ENTRY_INDEX_SIZE:0] mem_len_q;

  logic i_elig;
  logic d_elig;
  logic grant_i;
  logic grant_d;

  // A requester seeing DONE/ERROR this cycle is masked for one cycle.
  always_comb begin
    i_elig  = vis_active(i_vis_signal) && !st_final(i_status_q);
    d_elig  = vis_active(d_vis_signal) && !st_final(d_status_q);
    grant_i = i_elig && (!d_elig || last_d_q);
    grant_d = d_elig && (!i_elig || !last_d_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      last_d_q    <= 1'b1;
      wd_q        <= '0;
      i_status_q  <= ST_IDLE;
      d_status_q  <= ST_IDLE;
      i_data_q    <= '0;
      d_data_q    <= '0;
      mem_sig_q   <= VIS_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_type_q  <= '0;
      mem_len_q   <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          wd_q       <= '0;
          i_status_q <= grant_i ? ST_BUSY : ST_IDLE;
          d_status_q <= grant_d ? ST_BUSY : ST_IDLE;
          if (grant_i) begin
            state_q     <= ARB_BUSY_I;
            last_d_q    <= 1'b0;
            mem_sig_q   <= VIS_READ;
            mem_addr_q  <= i_vis_addr;
            mem_wdata_q <= '0;
            mem_type_q  <= '0;
            mem_len_q   <= '0;
          end else if (grant_d) begin
            state_q     <= ARB_BUSY_D;
            last_d_q    <= 1'b1;
            mem_sig_q   <= d_vis_signal;
            mem_addr_q  <= d_vis_addr;
            mem_wdata_q <= d_written_data;
            mem_type_q  <= d_data_type;
            mem_len_q   <= d_length;
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          if (mem_status == ST_DONE) begin
            if (state_q == ARB_BUSY_I) begin
              i_data_q   <= mem_data;
              i_status_q <= ST_DONE;
            end else begin
              d_data_q   <= mem_data;
              d_status_q <= ST_DONE;
            end
            mem_sig_q <= VIS_IDLE;
            state_q   <= ARB_IDLE;
            wd_q      <= '0;
          end else if (wd_q == WD_MAX) begin
            if (state_q == ARB_BUSY_I) begin
              i_status_q <= ST_ERROR;
            end else begin
              d_status_q <= ST_ERROR;
            end
            mem_sig_q <= VIS_IDLE;
            state_q   <= ARB_IDLE;
            wd_q      <= '0;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign i_status         = i_status_q;
  assign d_status         = d_status_q;
  assign i_data           = i_data_q;
  assign d_data           = d_data_q;
  assign mem_vis_signal   = mem_sig_q;
  assign mem_vis_addr     = mem_addr_q;
  assign mem_written_data = mem_wdata_q;
  assign mem_data_type    = mem_type_q;
  assign mem_length       = mem_len_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_defs::*;

  localparam int AW  = 17;
  localparam int L   = 32;
  localparam int EW  = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    i_vis_signal;
  logic [AW-1:0] i_vis_addr;
  logic [1:0]    i_status;
  logic [L-1:0]  i_data;
  logic [1:0]    d_vis_signal;
  logic [AW-1:0] d_vis_addr;
  logic [L-1:0]  d_written_data;
  logic [2:0]    d_data_type;
  logic [EW-1:0] d_length;
  logic [1:0]    d_status;
  logic [L-1:0]  d_data;
  logic [1:0]    mem_vis_signal;
  logic [AW-1:0] mem_vis_addr;
  logic [L-1:0]  mem_written_data;
  logic [2:0]    mem_data_type;
  logic [EW-1:0] mem_length;
  logic [1:0]    mem_status;
  logic [L-1:0]  mem_data;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .LEN(L), .ENTRY_INDEX_SIZE(EW-1), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_vis_signal(i_vis_signal), .i_vis_addr(i_vis_addr),
    .i_status(i_status), .i_data(i_data),
    .d_vis_signal(d_vis_signal), .d_vis_addr(d_vis_addr),
    .d_written_data(d_written_data), .d_data_type(d_data_type),
    .d_length(d_length), .d_status(d_status), .d_data(d_data),
    .mem_vis_signal(mem_vis_signal), .mem_vis_addr(mem_vis_addr),
    .mem_written_data(mem_written_data), .mem_data_type(mem_data_type),
    .mem_length(mem_length), .mem_status(mem_status), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_vis_signal = VIS_IDLE; i_vis_addr = '0;
    d_vis_signal = VIS_IDLE; d_vis_addr = '0;
    d_written_data = '0; d_data_type = '0; d_length = '0;
    mem_status = ST_IDLE; mem_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    tick(); tick();
    checks++; if ({i_status, d_status, mem_vis_signal} !== 6'd0) begin errors++; $display("FAIL reset_status got=%h exp=0", {i_status, d_status, mem_vis_signal}); end
    checks++; if ({i_data, d_data, mem_vis_addr, mem_written_data, mem_data_type, mem_length} !== '0) begin errors++; $display("FAIL reset_data got nonzero data/bus"); end
    rst = 1'b1;
  endtask

  task automatic test_i_read();
    i_vis_signal = VIS_READ; i_vis_addr = 17'h00040;
    tick();
    checks++; if (i_status !== ST_BUSY || mem_vis_signal !== VIS_READ || mem_vis_addr !== 17'h00040) begin errors++; $display("FAIL i_grant got st=%0d sig=%0d addr=%h exp 1 1 00040", i_status, mem_vis_signal, mem_vis_addr); end
    mem_status = ST_BUSY;
    tick(); tick();
    checks++; if (i_status !== ST_BUSY || d_status !== ST_IDLE) begin errors++; $display("FAIL i_wait got i=%0d d=%0d exp 1 0", i_status, d_status); end
    mem_status = ST_DONE; mem_data = 32'hDEADBEEF;
    tick();
    checks++; if (i_status !== ST_DONE || i_data !== 32'hDEADBEEF || mem_vis_signal !== VIS_IDLE) begin errors++; $display("FAIL i_done got st=%0d data=%h sig=%0d exp 2 deadbeef 0", i_status, i_data, mem_vis_signal); end
    i_vis_signal = VIS_IDLE; mem_status = ST_IDLE; mem_data = 32'h0;
    tick();
    checks++; if (i_status !== ST_IDLE || i_data !== 32'hDEADBEEF || d_status !== ST_IDLE) begin errors++; $display("FAIL i_after got st=%0d data=%h d=%0d exp 0 deadbeef 0", i_status, i_data, d_status); end
  endtask

  task automatic test_tie();
    rst = 1'b0; idle_inputs(); tick(); rst = 1'b1;
    i_vis_signal = VIS_READ; i_vis_addr = 17'h11;
    d_vis_signal = VIS_READ; d_vis_addr = 17'h22;
    tick();
    checks++; if (i_status !== ST_BUSY || d_status !== ST_IDLE || mem_vis_addr !== 17'h11) begin errors++; $display("FAIL tie_first got i=%0d d=%0d addr=%h exp 1 0 11", i_status, d_status, mem_vis_addr); end
    mem_status = ST_DONE; mem_data = 32'h1111;
    tick();
    checks++; if (i_status !== ST_DONE || d_status !== ST_IDLE) begin errors++; $display("FAIL tie_idone got i=%0d d=%0d exp 2 0", i_status, d_status); end
    mem_status = ST_IDLE;
    tick();
    checks++; if (d_status !== ST_BUSY || i_status !== ST_IDLE || mem_vis_addr !== 17'h22) begin errors++; $display("FAIL tie_second got d=%0d i=%0d addr=%h exp 1 0 22", d_status, i_status, mem_vis_addr); end
    mem_status = ST_DONE; mem_data = 32'h2222;
    tick();
    checks++; if (d_status !== ST_DONE || d_data !== 32'h2222) begin errors++; $display("FAIL tie_ddone got st=%0d data=%h exp 2 2222", d_status, d_data); end
    idle_inputs();
    tick();
    i_vis_signal = VIS_READ; i_vis_addr = 17'h33;
    tick();
    i_vis_signal = VIS_IDLE; mem_status = ST_DONE;
    tick();
    mem_status = ST_IDLE;
    tick();
    i_vis_signal = VIS_READ; i_vis_addr = 17'h44;
    d_vis_signal = VIS_READ; d_vis_addr = 17'h55;
    tick();
    checks++; if (d_status !== ST_BUSY || i_status !== ST_IDLE || mem_vis_addr !== 17'h55) begin errors++; $display("FAIL tie_to_d got d=%0d i=%0d addr=%h exp 1 0 55", d_status, i_status, mem_vis_addr); end
    mem_status = ST_DONE;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_d_write();
    d_vis_signal = VIS_WRITE; d_vis_addr = 17'h00100;
    d_written_data = 32'h12345678; d_data_type = 3'b010; d_length = 4'd4;
    tick();
    checks++; if ({mem_vis_signal, mem_vis_addr, mem_written_data, mem_data_type, mem_length} !== {VIS_WRITE, 17'h00100, 32'h12345678, 3'b010, 4'd4}) begin errors++; $display("FAIL d_write_bus got sig=%0d addr=%h wd=%h ty=%0d len=%0d", mem_vis_signal, mem_vis_addr, mem_written_data, mem_data_type, mem_length); end
    mem_status = ST_BUSY;
    tick();
    mem_status = ST_DONE; mem_data = 32'hA5A5A5A5;
    tick();
    checks++; if (d_status !== ST_DONE || d_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL d_write_done got st=%0d data=%h exp 2 a5a5a5a5", d_status, d_data); end
    idle_inputs();
    tick();
    checks++; if (d_status !== ST_IDLE) begin errors++; $display("FAIL d_write_pulse got st=%0d exp 0", d_status); end
  endtask

  task automatic test_withdraw();
    i_vis_signal = VIS_READ; i_vis_addr = 17'h00200;
    tick();
    i_vis_signal = VIS_IDLE; i_vis_addr = 17'h003FF; mem_status = ST_BUSY;
    tick();
    checks++; if (mem_vis_addr !== 17'h00200 || mem_vis_signal !== VIS_READ) begin errors++; $display("FAIL withdraw_hold got addr=%h sig=%0d exp 00200 1", mem_vis_addr, mem_vis_signal); end
    mem_status = ST_DONE; mem_data = 32'h55;
    tick();
    checks++; if (i_status !== ST_DONE || i_data !== 32'h55) begin errors++; $display("FAIL withdraw_done got st=%0d data=%h exp 2 55", i_status, i_data); end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    int busy_cnt;
    i_vis_signal = VIS_READ; i_vis_addr = 17'h0AAA;
    d_vis_signal = VIS_READ; d_vis_addr = 17'h0BBB;
    tick();
    checks++; if (d_status !== ST_BUSY || mem_vis_addr !== 17'h0BBB) begin errors++; $display("FAIL to_grant got d=%0d addr=%h exp 1 0bbb", d_status, mem_vis_addr); end
    mem_status = ST_BUSY;
    busy_cnt = 0;
    for (int k = 0; k < TMO; k++) begin
      tick();
      if (d_status == ST_BUSY) busy_cnt++;
    end
    checks++; if (busy_cnt !== TMO) begin errors++; $display("FAIL to_busy got=%0d exp=%0d", busy_cnt, TMO); end
    tick();
    checks++; if (d_status !== ST_ERROR || i_status !== ST_IDLE || mem_vis_signal !== VIS_IDLE) begin errors++; $display("FAIL to_error got d=%0d i=%0d sig=%0d exp 3 0 0", d_status, i_status, mem_vis_signal); end
    tick();
    checks++; if (i_status !== ST_BUSY || d_status !== ST_IDLE || mem_vis_addr !== 17'h0AAA) begin errors++; $display("FAIL to_next got i=%0d d=%0d addr=%h exp 1 0 0aaa", i_status, d_status, mem_vis_addr); end
    mem_status = ST_DONE;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    d_vis_signal = VIS_WRITE; d_vis_addr = 17'h777; d_written_data = 32'h99;
    tick();
    mem_status = ST_BUSY;
    tick();
    rst = 1'b0; mem_status = ST_DONE; mem_data = 32'hCAFE;
    tick();
    checks++; if ({i_status, d_status, i_data, d_data, mem_vis_signal, mem_vis_addr, mem_written_data} !== '0) begin errors++; $display("FAIL rst_mid got d=%0d ddata=%h sig=%0d exp all 0", d_status, d_data, mem_vis_signal); end
    rst = 1'b1; mem_status = ST_IDLE;
    tick();
    checks++; if (d_status !== ST_BUSY || mem_vis_addr !== 17'h777 || mem_vis_signal !== VIS_WRITE) begin errors++; $display("FAIL rst_regrant got d=%0d addr=%h sig=%0d exp 1 777 2", d_status, mem_vis_addr, mem_vis_signal); end
    mem_status = ST_DONE;
    tick();
    idle_inputs();
    tick();
  endtask

  // Reference: one owner at a time; timeout measured from the grant cycle.
  task automatic test_random();
    int owner, gt, last, mleft, pick;
    bit mact, ireq, dreq;
    logic [1:0] e_ist, e_dst, e_msig;
    logic [L-1:0] e_idat, e_ddat, e_mwd;
    logic [AW-1:0] e_maddr;
    logic [2:0] e_mtype;
    logic [EW-1:0] e_mlen;
    rst = 1'b0; idle_inputs(); tick(); rst = 1'b1;
    owner = 0; gt = 0; last = 2; mleft = 0; mact = 0;
    e_ist = 0; e_dst = 0; e_msig = 0; e_idat = 0; e_ddat = 0;
    e_mwd = 0; e_maddr = 0; e_mtype = 0; e_mlen = 0;
    for (int n = 0; n < 1500; n++) begin
      checks++; if ({i_status, d_status, i_data, d_data} !== {e_ist, e_dst, e_idat, e_ddat}) begin errors++; $display("FAIL rnd_resp n=%0d got i=%0d d=%0d %h %h exp %0d %0d %h %h", n, i_status, d_status, i_data, d_data, e_ist, e_dst, e_idat, e_ddat); end
      checks++; if ({mem_vis_signal, mem_vis_addr, mem_written_data, mem_data_type, mem_length} !== {e_msig, e_maddr, e_mwd, e_mtype, e_mlen}) begin errors++; $display("FAIL rnd_bus n=%0d got sig=%0d addr=%h exp sig=%0d addr=%h", n, mem_vis_signal, mem_vis_addr, e_msig, e_maddr); end
      if ($urandom_range(2) == 0) begin
        i_vis_signal = 2'($urandom); i_vis_addr = AW'($urandom);
      end
      if ($urandom_range(2) == 0) begin
        d_vis_signal = 2'($urandom); d_vis_addr = AW'($urandom);
        d_written_data = $urandom; d_data_type = 3'($urandom); d_length = EW'($urandom);
      end
      if (e_msig == VIS_IDLE) begin
        mact = 0; mem_status = ST_IDLE;
      end else begin
        if (!mact) begin
          mact = 1;
          mleft = ($urandom_range(7) == 0) ? 30 : $urandom_range(3);
        end
        if (mleft == 0) begin
          mem_status = ST_DONE; mem_data = $urandom;
        end else begin
          mem_status = ST_BUSY; mleft--;
        end
      end
      rst = ($urandom_range(99) != 0);
      if (!rst) begin
        owner = 0; last = 2;
        e_ist = 0; e_dst = 0; e_msig = 0; e_idat = 0; e_ddat = 0;
        e_mwd = 0; e_maddr = 0; e_mtype = 0; e_mlen = 0;
      end else if (owner == 0) begin
        ireq = (i_vis_signal == VIS_READ || i_vis_signal == VIS_WRITE) && e_ist != ST_DONE && e_ist != ST_ERROR;
        dreq = (d_vis_signal == VIS_READ || d_vis_signal == VIS_WRITE) && e_dst != ST_DONE && e_dst != ST_ERROR;
        pick = (ireq && dreq) ? ((last == 2) ? 1 : 2) : ireq ? 1 : dreq ? 2 : 0;
        e_ist = (pick == 1) ? ST_BUSY : ST_IDLE;
        e_dst = (pick == 2) ? ST_BUSY : ST_IDLE;
        if (pick == 1) begin
          e_msig = VIS_READ; e_maddr = i_vis_addr; e_mwd = 0; e_mtype = 0; e_mlen = 0;
        end else if (pick == 2) begin
          e_msig = d_vis_signal; e_maddr = d_vis_addr; e_mwd = d_written_data;
          e_mtype = d_data_type; e_mlen = d_length;
        end
        if (pick != 0) begin
          owner = pick; last = pick; gt = n;
        end
      end else if (mem_status == ST_DONE) begin
        if (owner == 1) begin e_ist = ST_DONE; e_idat = mem_data; end
        else begin e_dst = ST_DONE; e_ddat = mem_data; end
        e_msig = VIS_IDLE; owner = 0;
      end else if (n - gt == TMO + 1) begin
        if (owner == 1) e_ist = ST_ERROR;
        else e_dst = ST_ERROR;
        e_msig = VIS_IDLE; owner = 0;
      end
      tick();
    end
    rst = 1'b1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_tie();
    test_d_write();
    test_withdraw();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
